q_sys_pio_txm_dat: RTL
======================

Name: q_sys_pio_txm_dat

Overview:
- Transmit-side counterpart of the receive data PIO: the Nios II master writes 32-bit words over Avalon-MM.
- Words are buffered in a small FIFO and presented on out_port with a valid/ready handshake to fabric logic.
- Provides status, control and a sent-word counter so software can pace transmission without polling the external side.

Parameters:
- DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
- RESET_ENABLE, 1, reset value of control.enable.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- address  input  2  Avalon register select.
- chipselect  input  1  Avalon slave select; qualifies write.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  32  FIFO head word.
- out_valid  output  1  head word valid.
- out_ready  input  1  downstream accepts word.

Behaviour:
- Register map (word addresses):
  - 0 DATA: write pushes writedata; read returns the last word written (shadow register, reset 0).
  - 1 STATUS (read):
    - bit0 full; bit1 empty; bit2 overflow (sticky).
    - bits[15:8] = count, zero-extended.
    - Writing 1 to bit2 clears overflow; other bits ignore writes.
  - 2 CONTROL:
    - bit0 enable (R/W, reset RESET_ENABLE).
    - bit1 flush: write-1 self-clearing pulse, always reads 0.
  - 3 SENT: 32-bit count of completed handshakes; any write clears it to 0.
- Write accepted when chipselect=1 and write_n=0. No wait states.
- readdata:
  - Updated every cycle with mux(address), matching the existing PIO read timing; read latency 1.
  - Reset value 0.
  - Unused bits read 0.
- Push:
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - When full with no pop, the word is dropped, overflow is set and DATA shadow is still updated.
- Handshake:
  - out_valid = enable and (count>0).
  - Pop when out_valid and out_ready.
  - out_port = head word when count>0, else 0.
  - out_port holds stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- No fall-through: a word pushed in cycle N is first visible on out_port/out_valid in cycle N+1.
- Push and pop in the same cycle: count unchanged, both take effect.
- enable=0:
  - out_valid forced 0; FIFO contents and count are retained.
  - Pushes are still accepted.
  - Re-enabling resumes from the same head word.
- Flush write:
  - Next cycle count=0, read/write pointers=0.
  - Any push or pop coincident with the flush write is discarded; SENT is not incremented for a discarded pop.
- SENT:
  - Increments by 1 per pop.
  - Wraps 0xFFFFFFFF->0.
  - Clear write coincident with a pop yields 0.
- Simultaneous CONTROL write with enable 1->0 during a handshake cycle: the pop in that cycle completes, since out_valid is based on the registered enable.
- Reset:
  - FIFO empty, pointers 0, overflow 0, SENT 0, DATA shadow 0, readdata 0.
  - out_valid 0, out_port 0, enable=RESET_ENABLE.
  - Reset mid-transfer discards all buffered words.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then read addr1 -> readdata 0x00000002 one cycle after address is applied; out_valid=0, out_port=0.
- out_ready=1, write 0xDEADBEEF to addr0 -> out_valid=1 with out_port=0xDEADBEEF the next cycle for exactly 1 cycle. SENT reads 1. DATA reads 0xDEADBEEF.
- out_ready=0, write 5 words 0x1..0x5 (DEPTH=4):
  - STATUS reads full=1, overflow=1, count=4.
  - Raise out_ready -> out_port sequence 0x1,0x2,0x3,0x4, then out_valid=0; SENT=4.
- FIFO full with out_ready=1 while writing 0xA in the same cycle -> push accepted, count stays 4, 0xA emitted last, overflow not set.
- enable=0, push 2 words, hold 10 cycles -> out_valid=0, count=2. Then enable=1 -> both words emitted in order. Then write flush with 3 queued words and out_ready=0 -> next cycle empty=1, out_valid=0, SENT unchanged.
- Preload SENT to 0xFFFFFFFF via 2^32-1 handshakes (force in bench), one more pop -> SENT=0. Write addr3 coincident with a pop -> SENT=0.

Source files
------------

// File: rtl/q_sys_pio_txm_dat.sv
// ---------------------------------------------------------------------------
// q_sys_pio_txm_dat
//   Transmit data PIO. The Avalon-MM master (Nios II) writes 32-bit words
//   into a small FIFO. The FIFO head is presented to fabric logic on out_port
//   under a valid/ready handshake. The block also exposes status, control and
//   a sent-word counter, so software can pace transmission without polling
//   the external side.
//
// Parameters
//   DEPTH         FIFO depth in words (power of 2, >= 2)
//   RESET_ENABLE  reset value of CONTROL.enable
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   address     Avalon word address (0 DATA, 1 STATUS, 2 CONTROL, 3 SENT)
//   chipselect  Avalon slave select, qualifies write
//   write_n     active-low write strobe
//   writedata   Avalon write data
//   readdata    registered read data (mux of address, latency 1)
//   out_port    FIFO head word (0 when empty)
//   out_valid   head word valid (enable && not empty)
//   out_ready   downstream accepts the head word
// ---------------------------------------------------------------------------
module q_sys_pio_txm_dat #(
    parameter int unsigned DEPTH        = 4,
    parameter bit          RESET_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_port,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_SENT    = 2'd3;

    // Registered state
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;
    logic          enable_q,   enable_d;
    logic [31:0]   data_q,     data_d;
    logic [31:0]   sent_q,     sent_d;
    logic [31:0]   readdata_q, readdata_d;

    // Decoded strobes
    logic wr_en;
    logic push_req;
    logic flush_req;
    logic full;
    logic empty;
    logic pop_raw;
    logic pop_ok;
    logic push_ok;

    always_comb begin
        wr_en     = chipselect && !write_n;
        push_req  = wr_en && (address == ADDR_DATA);
        flush_req = wr_en && (address == ADDR_CONTROL) && writedata[1];
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        // out_valid uses the registered enable, so a CONTROL write that
        // disables output still lets a handshake in the same cycle complete.
        pop_raw   = enable_q && !empty && out_ready;
        // A flush discards any coincident pop (and it is then not counted).
        pop_ok    = pop_raw && !flush_req;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = push_req && (!full || pop_raw) && !flush_req;
    end

    // FIFO storage: no reset needed, visibility is governed by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= writedata;
        end
    end

    // Next-state logic for pointers, count and software registers.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        enable_d   = enable_q;
        data_d     = data_q;
        sent_d     = sent_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // DATA shadow tracks every write, even a dropped one.
        if (push_req) begin
            data_d = writedata;
            if (full && !pop_raw) begin
                overflow_d = 1'b1;
            end
        end

        if (wr_en && (address == ADDR_STATUS) && writedata[2]) begin
            overflow_d = 1'b0;
        end

        if (wr_en && (address == ADDR_CONTROL)) begin
            enable_d = writedata[0];
        end

        // Clear wins over a coincident pop.
        if (wr_en && (address == ADDR_SENT)) begin
            sent_d = '0;
        end else if (pop_ok) begin
            sent_d = sent_q + 32'd1;
        end
    end

    // Read mux: sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA: begin
                readdata_d = data_q;
            end
            ADDR_STATUS: begin
                readdata_d[0]      = full;
                readdata_d[1]      = empty;
                readdata_d[2]      = overflow_q;
                readdata_d[15:8]   = 8'(count_q);
            end
            ADDR_CONTROL: begin
                readdata_d[0] = enable_q;
            end
            ADDR_SENT: begin
                readdata_d = sent_q;
            end
            default: begin
                readdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= RESET_ENABLE;
            data_q     <= '0;
            sent_q     <= '0;
            readdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            data_q     <= data_d;
            sent_q     <= sent_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        readdata  = readdata_q;
        out_valid = enable_q && !empty;
        out_port  = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule
